// File: rtl/edge_qualifier_if.sv
// Signal bundle for the edge qualifier: control inputs and the qualified level/strobe/count outputs.
interface edge_qualifier_if #(
    parameter int unsigned CNT_W = 8
);
    logic             en;
    logic             sig_in;
    logic             clear_cnt;
    logic             sig_out;
    logic             rise;
    logic             fall;
    logic             busy;
    logic [CNT_W-1:0] glitch_cnt;

    modport master (
        output en, sig_in, clear_cnt,
        input  sig_out, rise, fall, busy, glitch_cnt
    );

    modport slave (
        input  en, sig_in, clear_cnt,
        output sig_out, rise, fall, busy, glitch_cnt
    );
endinterface

// File: rtl/edge_qualifier.sv
// Synchronises an asynchronous pulse line, rejects glitches shorter than FILTER_LEN+1 cycles and
// emits a registered clean level with rise/fall strobes plus a saturating rejected-glitch count.
module edge_qualifier #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILTER_LEN  = 3,
    parameter int unsigned CNT_W       = 8
) (
    input logic             clk,
    input logic             reset,
    edge_qualifier_if.slave bus
);
    localparam int unsigned StabW = $clog2(FILTER_LEN + 1);
    localparam logic [StabW-1:0] FilterMax = StabW'(FILTER_LEN);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [1:0] {StLo, PendHi, StHi, PendLo} state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    state_e                 state_q, state_d;
    logic [StabW-1:0]       stab_q, stab_d;
    logic                   sig_q, sig_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   busy_q, busy_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   glitch;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The synchroniser ignores en so sync_s is always current when qualification resumes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.sig_in};
        end
    end

    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        sig_d   = sig_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        glitch  = 1'b0;
        case (state_q)
            StLo: begin
                if (bus.en && sync_s) begin
                    state_d = PendHi;
                    stab_d  = StabW'(1);
                end
            end
            PendHi: begin
                if (!bus.en) begin
                    state_d = StLo;
                    stab_d  = '0;
                end else if (sync_s) begin
                    if (stab_q == FilterMax) begin
                        state_d = StHi;
                        stab_d  = '0;
                        sig_d   = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end else begin
                    state_d = StLo;
                    stab_d  = '0;
                    glitch  = 1'b1;
                end
            end
            StHi: begin
                if (bus.en && !sync_s) begin
                    state_d = PendLo;
                    stab_d  = StabW'(1);
                end
            end
            PendLo: begin
                if (!bus.en) begin
                    state_d = StHi;
                    stab_d  = '0;
                end else if (!sync_s) begin
                    if (stab_q == FilterMax) begin
                        state_d = StLo;
                        stab_d  = '0;
                        sig_d   = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end else begin
                    state_d = StHi;
                    stab_d  = '0;
                    glitch  = 1'b1;
                end
            end
            default: begin
                state_d = StLo;
                stab_d  = '0;
                sig_d   = 1'b0;
            end
        endcase

        busy_d = (state_d == PendHi) || (state_d == PendLo);

        // Clear takes priority over a same-cycle rejection.
        cnt_d = cnt_q;
        if (bus.clear_cnt) begin
            cnt_d = '0;
        end else if (glitch && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLo;
            stab_q  <= '0;
            sig_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            sig_q   <= sig_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sig_out    = sig_q;
    assign bus.rise       = rise_q;
    assign bus.fall       = fall_q;
    assign bus.busy       = busy_q;
    assign bus.glitch_cnt = cnt_q;
endmodule

// File: tb/tb_edge_qualifier.sv
// Bench for edge_qualifier: run-length reference model checked every cycle, directed scenarios
// with literal expectations, then randomized pulse trains.
module tb_edge_qualifier;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned FILTER_LEN  = 3;
    localparam int unsigned CNT_W       = 2;
    localparam int          GMAX        = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;

    edge_qualifier_if #(.CNT_W(CNT_W)) bus ();

    edge_qualifier #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILTER_LEN (FILTER_LEN),
        .CNT_W      (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted level plus length of the current run of differing samples.
    bit m_level = 0;
    int m_run   = 0;
    bit m_rise  = 0;
    bit m_fall  = 0;
    int m_gcnt  = 0;
    bit hist[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_init();
        m_level = 0;
        m_run   = 0;
        m_rise  = 0;
        m_fall  = 0;
        m_gcnt  = 0;
        hist.delete();
        for (int i = 0; i < int'(SYNC_STAGES); i++) hist.push_front(1'b0);
    endtask

    initial begin
        model_init();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                model_init();
            end else begin
                bit s;
                bit glitch;
                s = hist[$];
                void'(hist.pop_back());
                hist.push_front(bus.sig_in);
                m_rise = 0;
                m_fall = 0;
                glitch = 0;
                if (!bus.en) begin
                    m_run = 0;
                end else if (s != m_level) begin
                    m_run++;
                    if (m_run == int'(FILTER_LEN) + 1) begin
                        m_level = s;
                        m_rise  = s;
                        m_fall  = !s;
                        m_run   = 0;
                    end
                end else begin
                    glitch = (m_run > 0);
                    m_run  = 0;
                end
                if (bus.clear_cnt) m_gcnt = 0;
                else if (glitch && m_gcnt < GMAX) m_gcnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("sig_out", int'(bus.sig_out), int'(m_level));
            chk("rise", int'(bus.rise), int'(m_rise));
            chk("fall", int'(bus.fall), int'(m_fall));
            chk("busy", int'(bus.busy), int'(m_run > 0));
            chk("glitch_cnt", int'(bus.glitch_cnt), m_gcnt);
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic glitch1();
        bus.sig_in = 1'b1;
        tick();
        bus.sig_in = 1'b0;
        tick(3);
    endtask

    initial begin
        bus.en        = 1'b1;
        bus.sig_in    = 1'b0;
        bus.clear_cnt = 1'b0;
        tick(3);
        chk("reset_sig_out", int'(bus.sig_out), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_gcnt", int'(bus.glitch_cnt), 0);
        reset = 1'b0;
        tick(3);

        // Rise latency: committed at edge SYNC_STAGES+FILTER_LEN.
        bus.sig_in = 1'b1;
        tick(3);
        chk("rise_busy_e2", int'(bus.busy), 1);
        tick(2);
        chk("rise_sig_e4", int'(bus.sig_out), 0);
        chk("rise_busy_e4", int'(bus.busy), 1);
        tick();
        chk("rise_sig_e5", int'(bus.sig_out), 1);
        chk("rise_strobe_e5", int'(bus.rise), 1);
        chk("rise_busy_e5", int'(bus.busy), 0);
        tick();
        chk("rise_strobe_e6", int'(bus.rise), 0);
        tick(14);
        chk("rise_gcnt", int'(bus.glitch_cnt), 0);

        // Fall latency.
        bus.sig_in = 1'b0;
        tick(5);
        chk("fall_sig_e4", int'(bus.sig_out), 1);
        tick();
        chk("fall_strobe_e5", int'(bus.fall), 1);
        chk("fall_sig_e5", int'(bus.sig_out), 0);
        tick();
        chk("fall_strobe_e6", int'(bus.fall), 0);
        tick(4);

        // Two-cycle glitch from low.
        bus.sig_in = 1'b1;
        tick(2);
        bus.sig_in = 1'b0;
        tick();
        chk("g2_busy_e2", int'(bus.busy), 1);
        tick();
        chk("g2_busy_e3", int'(bus.busy), 1);
        tick();
        chk("g2_busy_e4", int'(bus.busy), 0);
        chk("g2_gcnt", int'(bus.glitch_cnt), 1);
        chk("g2_sig", int'(bus.sig_out), 0);
        tick(3);

        // Further one-cycle glitches saturate at 3.
        for (int k = 2; k <= 5; k++) begin
            glitch1();
            chk("g1_gcnt", int'(bus.glitch_cnt), (k > 3) ? 3 : k);
            tick(2);
        end

        // Clear in the same cycle as a rejection.
        bus.sig_in = 1'b1;
        tick();
        bus.sig_in = 1'b0;
        tick(2);
        bus.clear_cnt = 1'b1;
        tick();
        bus.clear_cnt = 1'b0;
        chk("clr_gcnt", int'(bus.glitch_cnt), 0);
        chk("clr_busy", int'(bus.busy), 0);
        tick(3);

        // en drop during pending.
        bus.sig_in = 1'b1;
        tick(3);
        chk("en_busy_pend", int'(bus.busy), 1);
        bus.en = 1'b0;
        tick();
        chk("en_busy_drop", int'(bus.busy), 0);
        chk("en_gcnt", int'(bus.glitch_cnt), 0);
        tick(2);
        bus.en = 1'b1;
        tick(3);
        chk("en_sig_3", int'(bus.sig_out), 0);
        tick();
        chk("en_sig_4", int'(bus.sig_out), 1);
        chk("en_rise_4", int'(bus.rise), 1);
        tick(2);

        // Asynchronous reset while pending, release with the line high.
        bus.sig_in = 1'b0;
        tick(8);
        bus.sig_in = 1'b1;
        tick(3);
        chk("rst_busy_pre", int'(bus.busy), 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_sig", int'(bus.sig_out), 0);
        chk("rst_rise", int'(bus.rise), 0);
        chk("rst_fall", int'(bus.fall), 0);
        tick(2);
        reset = 1'b0;
        tick(5);
        chk("rel_rise_e4", int'(bus.rise), 0);
        tick();
        chk("rel_rise_e5", int'(bus.rise), 1);
        chk("rel_sig_e5", int'(bus.sig_out), 1);
        tick(2);

        // Randomized pulse trains with occasional en drops and clears.
        for (int b = 0; b < 400; b++) begin
            bus.sig_in = 1'($urandom_range(0, 1));
            for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
                bus.en        = ($urandom_range(0, 19) != 0);
                bus.clear_cnt = ($urandom_range(0, 29) == 0);
                tick();
            end
        end
        bus.en        = 1'b1;
        bus.clear_cnt = 1'b0;
        tick(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
